// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier sequencer that borrows the shared combinational ALU adder,
// one multiplier bit per cycle; returns the low XLEN bits of A*B.
module alu_mul_sequencer #(
  parameter int XLEN       = 64,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic            clk_in,
  input  logic            rstN_in,
  input  logic            reqValid_in,
  output logic            reqReady_out,
  input  logic [XLEN-1:0] multiplicand_in,
  input  logic [XLEN-1:0] multiplier_in,
  input  logic            abort_in,
  output logic            respValid_out,
  input  logic            respReady_in,
  output logic [XLEN-1:0] product_out,
  output logic            busy_out,
  output logic [XLEN-1:0] aluOperand1_out,
  output logic [XLEN-1:0] aluOperand2_out,
  output logic [2:0]      aluOpcode_out,
  input  logic [XLEN-1:0] aluResult_in
);
  localparam int          CW     = $clog2(XLEN);
  localparam logic [2:0]  OP_ADD = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q, prod_q, acc_nxt;
  logic [CW-1:0]   count_q;
  logic            accept, last_step;

  assign accept    = (state_q == S_IDLE) && reqValid_in && !abort_in;
  assign acc_nxt   = mplier_q[0] ? aluResult_in : acc_q;
  // Finish when the bit budget is spent, or early once no multiplier bits remain.
  assign last_step = (count_q == CW'(XLEN-1)) ||
                     (EARLY_TERM && ((mplier_q >> 1) == '0));

  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: if (last_step) state_d = S_DONE;
      S_DONE: if (respReady_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_in) state_d = S_IDLE;
  end

  always_comb begin
    reqReady_out    = 1'b0;
    respValid_out   = 1'b0;
    busy_out        = 1'b0;
    aluOperand1_out = '0;
    aluOperand2_out = '0;
    aluOpcode_out   = OP_ADD;
    case (state_q)
      S_IDLE: reqReady_out = 1'b1;
      S_BUSY: begin
        busy_out        = 1'b1;
        aluOperand1_out = acc_q;
        aluOperand2_out = mcand_q;
      end
      S_DONE: respValid_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (abort_in) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= multiplicand_in;
      mplier_q <= multiplier_in;
      count_q  <= '0;
    end else if (state_q == S_BUSY) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
    end
  end

  // Separate result register so the product survives into IDLE, even past an abort.
  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in)                                          prod_q <= '0;
    else if (state_q == S_BUSY && last_step && !abort_in)  prod_q <= acc_nxt;
  end

  assign product_out = prod_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized self-checking bench: unit 0 uses EARLY_TERM=1, unit 1 EARLY_TERM=0,
// each paired with a behavioural adder standing in for the shared ALU.
module tb_alu_mul_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [63:0] op_a      [2];
  logic [63:0] op_b      [2];
  logic        abort     [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [63:0] product   [2];
  logic        busy      [2];
  logic [63:0] alu_op1   [2];
  logic [63:0] alu_op2   [2];
  logic [2:0]  alu_opc   [2];
  logic [63:0] alu_res   [2];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign alu_res[0] = (alu_opc[0] == 3'b111) ? alu_op1[0] + alu_op2[0] : 64'd0;
  assign alu_res[1] = (alu_opc[1] == 3'b111) ? alu_op1[1] + alu_op2[1] : 64'd0;

  alu_mul_sequencer #(.XLEN(64), .EARLY_TERM(1'b1)) u_et (
    .clk_in(clk), .rstN_in(rst_n),
    .reqValid_in(req_valid[0]), .reqReady_out(req_ready[0]),
    .multiplicand_in(op_a[0]), .multiplier_in(op_b[0]), .abort_in(abort[0]),
    .respValid_out(resp_valid[0]), .respReady_in(resp_ready[0]), .product_out(product[0]),
    .busy_out(busy[0]), .aluOperand1_out(alu_op1[0]), .aluOperand2_out(alu_op2[0]),
    .aluOpcode_out(alu_opc[0]), .aluResult_in(alu_res[0]));

  alu_mul_sequencer #(.XLEN(64), .EARLY_TERM(1'b0)) u_full (
    .clk_in(clk), .rstN_in(rst_n),
    .reqValid_in(req_valid[1]), .reqReady_out(req_ready[1]),
    .multiplicand_in(op_a[1]), .multiplier_in(op_b[1]), .abort_in(abort[1]),
    .respValid_out(resp_valid[1]), .respReady_in(resp_ready[1]), .product_out(product[1]),
    .busy_out(busy[1]), .aluOperand1_out(alu_op1[1]), .aluOperand2_out(alu_op2[1]),
    .aluOpcode_out(alu_opc[1]), .aluResult_in(alu_res[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  // Reference latency: bit count of B (min 1) with early termination, else full width.
  function automatic int ref_lat(input int u, input logic [63:0] b);
    int hi;
    if (u == 1) return 64;
    hi = 0;
    for (int i = 0; i < 64; i++) if (b[i]) hi = i + 1;
    return (hi == 0) ? 1 : hi;
  endfunction

  task automatic chk_reset_outs(input int u, input string tag);
    chk({tag, ".ready"}, 64'(req_ready[u]), 64'd1);
    chk({tag, ".rvalid"}, 64'(resp_valid[u]), 64'd0);
    chk({tag, ".busy"}, 64'(busy[u]), 64'd0);
    chk({tag, ".prod"}, product[u], 64'd0);
    chk({tag, ".op1"}, alu_op1[u], 64'd0);
    chk({tag, ".op2"}, alu_op2[u], 64'd0);
    chk({tag, ".opc"}, 64'(alu_opc[u]), 64'd7);
  endtask

  // Issue a request; called #1 after a rising edge. Leaves the unit in DONE (sampled) on return.
  task automatic issue(input int u, input logic [63:0] a, input logic [63:0] b, output int n);
    req_valid[u] = 1'b1; op_a[u] = a; op_b[u] = b;
    @(posedge clk); #1;
    req_valid[u] = 1'b0; op_a[u] = $urandom; op_b[u] = $urandom;
    chk("first_busy", 64'(busy[u]), 64'd1);
    chk("first_op2", alu_op2[u], a);
    chk("first_op1", alu_op1[u], 64'd0);
    n = 0;
    while (!resp_valid[u] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_mul(input int u, input logic [63:0] a, input logic [63:0] b);
    int n;
    logic [63:0] exp_p;
    exp_p = a * b;
    issue(u, a, b, n);
    chk("latency", 64'(n), 64'(ref_lat(u, b)));
    chk("product", product[u], exp_p);
    if (n >= 200) begin
      abort[u] = 1'b1; @(posedge clk); #1; abort[u] = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk("back_idle", 64'(req_ready[u]), 64'd1);
      chk("idle_hold", product[u], exp_p);
    end
  endtask

  initial begin
    int n;
    logic [63:0] held;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; op_a[u] = '0; op_b[u] = '0;
      abort[u] = 1'b0; resp_ready[u] = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outs(0, "rst0");
    chk_reset_outs(1, "rst1");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    do_mul(0, 64'd3, 64'd5);
    do_mul(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    do_mul(0, 64'd1234, 64'd0);
    do_mul(0, 64'd7, 64'h8000_0000_0000_0000);

    // Back-pressure in DONE: output stable, new requests ignored.
    resp_ready[0] = 1'b0;
    issue(0, 64'd9, 64'd11, n);
    chk("bp_lat", 64'(n), 64'd4);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = 1'b1; op_a[0] = 64'd100; op_b[0] = 64'd100;
      @(posedge clk); #1;
      chk("bp_valid", 64'(resp_valid[0]), 64'd1);
      chk("bp_prod", product[0], 64'd99);
      chk("bp_ready", 64'(req_ready[0]), 64'd0);
    end
    req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(req_ready[0]), 64'd1);
    chk("bp_release_valid", 64'(resp_valid[0]), 64'd0);

    // Abort on the 10th BUSY cycle, with a competing request that must not be taken.
    req_valid[0] = 1'b1; op_a[0] = 64'd5; op_b[0] = 64'h0000_0100_0000_0000;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_abort_busy", 64'(busy[0]), 64'd1);
    abort[0] = 1'b1; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 64'(req_ready[0]), 64'd1);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_rvalid", 64'(resp_valid[0]), 64'd0);
    @(posedge clk); #1;
    chk("abort_req_dropped", 64'(busy[0]), 64'd0);
    abort[0] = 1'b0; req_valid[0] = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (resp_valid[0]) break;
    end
    chk("abort_no_resp", 64'(resp_valid[0]), 64'd0);
    do_mul(0, 64'd6, 64'd7);

    // Asynchronous reset between edges in the middle of an operation.
    do_mul(1, 64'd13, 64'd17);
    req_valid[1] = 1'b1; op_a[1] = 64'hDEAD_BEEF; op_b[1] = 64'h1234_5678_9ABC;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs(1, "async1");
    chk_reset_outs(0, "async0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rvalid", 64'(resp_valid[1]), 64'd0);

    // Random requests against plain multiplication.
    for (int k = 0; k < 1000; k++) begin
      logic [63:0] a, b;
      int u;
      u = (k % 4 == 3) ? 1 : 0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (k % 17 == 0) b = 64'd0;
      do_mul(u, a, b);
    end

    held = product[0];
    @(posedge clk); #1;
    chk("final_hold", product[0], held);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
